// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared geometry constants, fill FSM states and buffer indexing
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int SCR_W    = 640;
    localparam int SCR_H    = 480;
    localparam int FB_DEPTH = 76800;

    localparam int FB_XW    = 9;
    localparam int FB_YW    = 8;
    localparam int SCR_XW   = 10;
    localparam int SCR_YW   = 9;
    localparam int FB_AW    = 17;
    localparam int COLOR_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // y*320 + x built from two shifts so no multiplier is inferred
    function automatic logic [FB_AW-1:0] fb_index(input logic [FB_XW-1:0] bx,
                                                  input logic [FB_YW-1:0] by);
        logic [FB_AW-1:0] y_ext;
        y_ext = {{(FB_AW-FB_YW){1'b0}}, by};
        return (y_ext << 8) + (y_ext << 6) + {{(FB_AW-FB_XW){1'b0}}, bx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_ram.sv
`default_nettype none
// ============================================================================
// Module      : fb_ram
// Description : Simple dual-port frame buffer RAM, registered read-first port
// Revision    : 1.0 - initial release
// ============================================================================
module fb_ram
    import vga_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int WIDTH = COLOR_W,
    parameter int AW    = FB_AW
)(
    input  logic             vga_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_re,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;

    // Non-blocking write and read in one process gives read-first collisions
    always_ff @(posedge vga_clk) begin
        if (i_we)
            r_mem[i_wr_addr] <= i_wr_data;
        if (i_re)
            r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/vga_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : vga_framebuffer
// Description : 320x240 frame buffer, 2x doubled scan-out and rectangle fill
// Revision    : 1.0 - initial release
// ============================================================================
module vga_framebuffer #(
    parameter int FB_W  = vga_pkg::FB_W,
    parameter int FB_H  = vga_pkg::FB_H,
    parameter int SCR_W = vga_pkg::SCR_W
)(
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [18:0] addr,
    input  logic        rdn,
    output logic [11:0] color,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_x0,
    input  logic [8:0]  cmd_x1,
    input  logic [7:0]  cmd_y0,
    input  logic [7:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    output logic        busy,
    output logic        done
);

    import vga_pkg::*;

    localparam logic [8:0] c_X_MAX  = 9'(FB_W - 1);
    localparam logic [7:0] c_Y_MAX  = 8'(FB_H - 1);
    localparam logic [9:0] c_SX_MAX = 10'(SCR_W - 1);
    localparam logic [8:0] c_SY_MAX = 9'(SCR_H - 1);

    // ---------------- read side ----------------
    logic [9:0]  r_sx;
    logic [8:0]  r_sy;
    logic        w_addr_zero;
    logic [9:0]  w_px;
    logic [8:0]  w_py;
    logic [16:0] w_rd_addr;
    logic        r_rd_valid;
    logic [11:0] w_rd_data;

    assign w_addr_zero = (addr == '0);
    assign w_px        = w_addr_zero ? 10'd0 : r_sx;
    assign w_py        = w_addr_zero ? 9'd0  : r_sy;
    assign w_rd_addr   = fb_index(w_px[9:1], w_py[8:1]);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (!rdn) begin
            if (w_addr_zero) begin
                r_sx <= 10'd1;
                r_sy <= '0;
            end else if (r_sx == c_SX_MAX) begin
                r_sx <= '0;
                r_sy <= (r_sy == c_SY_MAX) ? 9'd0 : r_sy + 9'd1;
            end else begin
                r_sx <= r_sx + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst)
            r_rd_valid <= 1'b0;
        else
            r_rd_valid <= ~rdn;
    end

    assign color = r_rd_valid ? w_rd_data : 12'h000;

    // ---------------- fill engine ----------------
    fill_state_t r_state, w_state_nxt;
    logic [8:0]  r_cx, r_x0, r_x1c;
    logic [7:0]  r_cy, r_y1c;
    logic [11:0] r_fill_color;
    logic [8:0]  w_x1c;
    logic [7:0]  w_y1c;
    logic        w_degen;
    logic        w_accept;
    logic        w_row_end;
    logic        w_we;
    logic [16:0] w_wr_addr;

    assign w_x1c     = (cmd_x1 > c_X_MAX) ? c_X_MAX : cmd_x1;
    assign w_y1c     = (cmd_y1 > c_Y_MAX) ? c_Y_MAX : cmd_y1;
    assign w_degen   = (cmd_x0 > w_x1c) || (cmd_y0 > w_y1c) ||
                       (cmd_x0 > c_X_MAX) || (cmd_y0 > c_Y_MAX);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_row_end = (r_cx == r_x1c);
    assign w_wr_addr = fb_index(r_cx, r_cy);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_state_nxt = w_degen ? ST_DONE : ST_FILL;
            end
            ST_FILL: begin
                busy = 1'b1;
                w_we = 1'b1;
                if (w_row_end && (r_cy == r_y1c))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_cx         <= '0;
            r_cy         <= '0;
            r_x0         <= '0;
            r_x1c        <= '0;
            r_y1c        <= '0;
            r_fill_color <= '0;
        end else if (w_accept) begin
            r_cx         <= cmd_x0;
            r_cy         <= cmd_y0;
            r_x0         <= cmd_x0;
            r_x1c        <= w_x1c;
            r_y1c        <= w_y1c;
            r_fill_color <= cmd_color;
        end else if (r_state == ST_FILL) begin
            if (w_row_end) begin
                r_cx <= r_x0;
                r_cy <= r_cy + 8'd1;
            end else begin
                r_cx <= r_cx + 9'd1;
            end
        end
    end

    fb_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (COLOR_W),
        .AW    (FB_AW)
    ) u_fb_ram (
        .vga_clk   (vga_clk),
        .i_we      (w_we),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (r_fill_color),
        .i_re      (~rdn),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

endmodule
`default_nettype wire
